// File: rtl/seq_divider_if.sv
// Operand/result bundle between the multdiv issue logic and the sequential divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_DIV,
        input  data_result, data_remainder, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_DIV,
        output data_result, data_remainder, data_exception, data_resultRDY
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied on the final iteration; a new start always aborts the current op.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_rem, w_rem_nx;
    logic [WIDTH-1:0] r_quo, w_quo_nx;      // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] r_dsr, w_dsr_nx;
    logic [CW-1:0]    r_count, w_count_nx;
    logic             r_sign_q, w_sign_q_nx;
    logic             r_sign_r, w_sign_r_nx;
    logic             r_dz, w_dz_nx;
    logic [WIDTH-1:0] r_result, w_result_nx;
    logic [WIDTH-1:0] r_remainder, w_remainder_nx;
    logic             r_exc, w_exc_nx;
    logic             r_rdy, w_rdy_nx;

    logic [WIDTH:0]   w_shift, w_trial;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_step, w_r_step;

    assign w_a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign w_b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // One restoring step; the partial remainder never exceeds the divisor so WIDTH bits hold it.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_dsr};
    assign w_q_step = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_r_step = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_comb begin
        w_state_nx     = r_state;
        w_rem_nx       = r_rem;
        w_quo_nx       = r_quo;
        w_dsr_nx       = r_dsr;
        w_count_nx     = r_count;
        w_sign_q_nx    = r_sign_q;
        w_sign_r_nx    = r_sign_r;
        w_dz_nx        = r_dz;
        w_result_nx    = r_result;
        w_remainder_nx = r_remainder;
        w_exc_nx       = r_exc;
        w_rdy_nx       = 1'b0;

        if (bus.ctrl_DIV) begin
            w_state_nx  = S_RUN;
            w_rem_nx    = '0;
            w_quo_nx    = w_a_mag;
            w_dsr_nx    = w_b_mag;
            w_count_nx  = '0;
            w_sign_q_nx = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            w_sign_r_nx = bus.data_operandA[WIDTH-1];
            w_dz_nx     = (bus.data_operandB == '0);
        end else begin
            case (r_state)
                S_RUN: begin
                    w_rem_nx   = w_r_step;
                    w_quo_nx   = w_q_step;
                    w_count_nx = r_count + CW'(1);
                    if (r_count == LAST) begin
                        w_state_nx     = S_DONE;
                        w_rdy_nx       = 1'b1;
                        w_exc_nx       = r_dz;
                        w_result_nx    = r_dz ? '0 : (r_sign_q ? -w_q_step : w_q_step);
                        w_remainder_nx = r_dz ? '0 : (r_sign_r ? -w_r_step : w_r_step);
                    end
                end
                S_DONE:  w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_count     <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dz        <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exc       <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rem       <= w_rem_nx;
            r_quo       <= w_quo_nx;
            r_dsr       <= w_dsr_nx;
            r_count     <= w_count_nx;
            r_sign_q    <= w_sign_q_nx;
            r_sign_r    <= w_sign_r_nx;
            r_dz        <= w_dz_nx;
            r_result    <= w_result_nx;
            r_remainder <= w_remainder_nx;
            r_exc       <= w_exc_nx;
            r_rdy       <= w_rdy_nx;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_remainder = r_remainder;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a signed-arithmetic reference model with
// start/abort/reset timing, plus directed literal cases and randomised operations.
module tb_seq_divider;
    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        x;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seq_divider_if #(.WIDTH(WIDTH)) bus();
    seq_divider #(.WIDTH(WIDTH)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed division with truncation toward zero, evaluated in 64 bits so INT_MIN/-1 wraps cleanly.
    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
        res_t   res;
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
            res.q = 32'd0;
            res.r = 32'd0;
            res.x = 1'b1;
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            qq    = sa / sb;
            rr    = sa % sb;
            res.q = 32'(qq);
            res.r = 32'(rr);
            res.x = 1'b0;
        end
        return res;
    endfunction

    // Model: the most recent start completes LAT edges later unless restarted or reset.
    res_t        m_res  = '0;
    logic        m_rdy  = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_live = 1'b0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    longint      m_cyc  = 0;
    longint      m_due  = 0;

    always @(posedge clk) begin
        m_cyc  <= m_cyc + 1;
        m_live <= 1'b1;
        m_rdy  <= 1'b0;
        if (rst) begin
            m_pend <= 1'b0;
            m_res  <= '0;
        end else if (bus.ctrl_DIV) begin
            m_pend <= 1'b1;
            m_a    <= bus.data_operandA;
            m_b    <= bus.data_operandB;
            m_due  <= m_cyc + 1 + LAT;
        end else if (m_pend && (m_cyc + 1 == m_due)) begin
            m_res  <= ref_div(m_a, m_b);
            m_rdy  <= 1'b1;
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("rdy", 32'(bus.data_resultRDY), 32'(m_rdy));
            check("quotient", bus.data_result, m_res.q);
            check("remainder", bus.data_remainder, m_res.r);
            if (m_rdy) check("exception", 32'(bus.data_exception), 32'(m_res.x));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        tick();
        bus.ctrl_DIV      = 1'b0;
    endtask

    // Called just after the start edge; RDY must first be seen at the 33rd falling edge.
    task automatic wait_rdy(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.data_resultRDY !== 1'b1 && n < 80);
        check({name, "_latency"}, 32'(n), 32'(LAT + 1));
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input logic ex);
        start(a, b);
        wait_rdy(name);
        check({name, "_q"}, bus.data_result, eq);
        check({name, "_r"}, bus.data_remainder, er);
        check({name, "_x"}, 32'(bus.data_exception), 32'(ex));
        tick();
    endtask

    function automatic logic [31:0] rand_op(input bit divisor);
        case ($urandom_range(0, 7))
            0:       return divisor ? 32'd0 : 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            4:       return -32'($urandom_range(1, 40));
            5:       return 32'($urandom) >> $urandom_range(0, 31);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int          seen;
        logic [31:0] a, b, recon;

        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) tick();
        check("reset_q", bus.data_result, 32'd0);
        check("reset_r", bus.data_remainder, 32'd0);
        check("reset_x", 32'(bus.data_exception), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        rst = 1'b0;
        tick();

        check_op("pos",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        check_op("neg_a",    32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
        check_op("neg_b",    32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0);
        check_op("div_zero", 32'd5,          32'd0,          32'd0,          32'd0,          1'b1);
        check_op("after_dz", 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
        check_op("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        check_op("max",      32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0);

        // Abort at E10 with new operands: only the second op completes, 32 edges after E10.
        start(32'd100, 32'd7);
        repeat (9) tick();
        start(32'd50, 32'd5);
        wait_rdy("restart");
        check("restart_q", bus.data_result, 32'd10);
        check("restart_r", bus.data_remainder, 32'd0);
        tick();

        // Reset at E15 discards the op and clears the held outputs.
        start(32'd100, 32'd7);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        check("midrst_q", bus.data_result, 32'd0);
        check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        check("midrst_no_rdy", 32'(seen), 32'd0);
        tick();
        check_op("post_rst", 32'hFFFF_FC18, 32'd33, 32'hFFFF_FFE2, 32'hFFFF_FFF6, 1'b0);

        // Holding the start high restarts every edge; only the final start completes.
        bus.data_operandA = 32'd20;
        bus.data_operandB = 32'd4;
        bus.ctrl_DIV      = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        bus.ctrl_DIV = 1'b0;
        check("hold_no_rdy", 32'(seen), 32'd0);
        wait_rdy("hold");
        check("hold_q", bus.data_result, 32'd5);
        tick();

        for (int i = 0; i < 1000; i++) begin
            a = rand_op(1'b0);
            b = rand_op(1'b1);
            start(a, b);
            wait_rdy("rand");
            if (b != 32'd0) begin
                recon = bus.data_result * b + bus.data_remainder;
                check("rand_identity", recon, a);
            end
            if ($urandom_range(0, 1) == 0) tick();
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider for the ALU/multdiv datapath.
- It is the inverse operation of the multiplier: it takes a dividend and divisor and produces the quotient and remainder, one quotient bit per cycle.
- It accepts the same operand buses as the combinational ALU ops.
- The pipeline stalls on it until data_resultRDY pulses.

Parameters:
WIDTH, 32, operand/result width in bits (design and verification at 32 only)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
data_operandA  input  WIDTH  dividend, two's complement
data_operandB  input  WIDTH  divisor, two's complement
ctrl_DIV  input  1  start pulse; operands sampled on the same edge
data_result  output  WIDTH  quotient, registered
data_remainder  output  WIDTH  remainder, registered
data_exception  output  1  divide-by-zero flag, valid while data_resultRDY=1
data_resultRDY  output  1  single-cycle completion pulse

Behaviour:
- Reset (edge with reset=1):
  - state=IDLE, count=0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0.
  - reset has priority over ctrl_DIV.
- States:
  - IDLE: wait for ctrl_DIV.
  - RUN: 32 iterations.
  - DONE: one cycle with data_resultRDY=1.
- Start (edge E0 with ctrl_DIV=1):
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes; |0x80000000| = 0x80000000 unsigned.
  - Latch sign_q = A[31]^B[31], sign_r = A[31], and div_zero = (B==0).
  - Clear the partial remainder (WIDTH+1 bits) and count.
  - Enter RUN.
- RUN, edges E1..E32, restoring division:
  - shift {rem, dividend} left 1.
  - trial = rem - |B| (WIDTH+1 bits).
  - If trial is non-negative: rem = trial, shift in quotient bit 1; else shift in 0.
  - count increments each edge.
- Edge E32 (count reaches 31, final iteration):
  - data_result = sign_q ? -q : q.
  - data_remainder = sign_r ? -r : r.
  - data_exception = div_zero.
  - If div_zero: data_result=0 and data_remainder=0.
  - Enter DONE; data_resultRDY=1 for the cycle E32..E33.
- Edge E33: data_resultRDY=0, enter IDLE (or RUN if ctrl_DIV=1 on E33).
- Latency: the result is visible exactly 32 edges after the capture edge.
- data_result, data_remainder and data_exception hold their values until the next completion or reset. data_exception is only meaningful when data_resultRDY=1.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign; A = Q*B + R holds for all B≠0.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (two's-complement wrap), remainder 0, data_exception=0.
- Divide by zero still takes the full 32-cycle latency; no early exit.
- ctrl_DIV while in RUN or DONE aborts the current operation and restarts with the new operands at that edge. No data_resultRDY is produced for the aborted operation.
- Reset mid-RUN: operation is discarded; no data_resultRDY afterwards until a new start.
- ctrl_DIV is edge-sampled per cycle. Holding it high restarts every cycle, so data_resultRDY never fires; the issuer must pulse it for exactly one cycle.

Test Plan:
- A=100, B=7, pulse ctrl_DIV at E0 -> data_resultRDY=1 only in cycle E32..E33; result=14, remainder=2, exception=0; RDY low at all other cycles.
- A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> at E32: exception=1, result=0, remainder=0, RDY=1; next op A=9, B=3 -> exception=0, result=3.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0; A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF.
- A=100, B=7 start at E0; restart at E10 with A=50, B=5 -> no RDY at E32; RDY at E42..E43 with result=10, remainder=0.
- Start at E0, reset=1 at E15 -> all outputs 0 from E15 on, no RDY through E40; a new start afterwards completes normally.
- Randomised 1000 ops vs a signed reference model -> quotient and remainder match and A = Q*B + R for every op with B≠0.
